// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle core: opcode/funct encodings,
// instruction field positions, FSM states, the decoder's control bundle and
// the ALU evaluation function.
package proc_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  // R-type funct codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // Instruction field positions
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int SH_MSB = 10;
  localparam int SH_LSB = 6;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;
  localparam int IMM_MSB = 15;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

  typedef enum logic [1:0] {BR_EQ, BR_NE, BR_LEZ, BR_GTZ} br_t;

  typedef struct packed {
    alu_op_t alu_opcode;
    logic    reg_dst;    // 1: write rd, 0: write rt
    logic    alu_src;    // 1: B operand is sign-extended immediate
    logic    is_branch;
    br_t     branch_type;
    logic    is_jump;
    logic    link;       // jump writes return address
    logic    jump_src;   // 1: target from rs, 0: from address field
    logic    is_load;
    logic    is_store;
    logic    illegal;
  } ctrl_t;

  // Shifts act on b (the rt operand) by the shamt field.
  function automatic logic [31:0] alu_eval(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] y;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_SLT:  y = {31'b0, (sa < sb)};
      ALU_SLTU: y = {31'b0, (a < b)};
      ALU_SLL:  y = b << sh;
      ALU_SRL:  y = b >> sh;
      ALU_SRA:  y = sb >>> sh;
      default:  y = a + b;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/multicycle_decoder.sv
// Combinational instruction decoder.
// Ports:
//   i_opcode - instruction bits [31:26]
//   i_funct  - instruction bits [5:0]
//   o_ctrl   - control bundle; illegal=1 for any undefined opcode/funct.
//              The halt opcode yields an all-zero, legal bundle.
module multicycle_decoder
  import proc_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    o_ctrl.alu_opcode = ALU_ADD;
    o_ctrl.branch_type = BR_EQ;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.reg_dst = 1'b1;
        case (i_funct)
          F_ADD, F_ADDU: o_ctrl.alu_opcode = ALU_ADD;
          F_SUB, F_SUBU: o_ctrl.alu_opcode = ALU_SUB;
          F_AND:  o_ctrl.alu_opcode = ALU_AND;
          F_OR:   o_ctrl.alu_opcode = ALU_OR;
          F_XOR:  o_ctrl.alu_opcode = ALU_XOR;
          F_NOR:  o_ctrl.alu_opcode = ALU_NOR;
          F_SLT:  o_ctrl.alu_opcode = ALU_SLT;
          F_SLTU: o_ctrl.alu_opcode = ALU_SLTU;
          F_SLL:  o_ctrl.alu_opcode = ALU_SLL;
          F_SRL:  o_ctrl.alu_opcode = ALU_SRL;
          F_SRA:  o_ctrl.alu_opcode = ALU_SRA;
          F_JR: begin
            o_ctrl.is_jump  = 1'b1;
            o_ctrl.jump_src = 1'b1;
          end
          F_JALR: begin
            o_ctrl.is_jump  = 1'b1;
            o_ctrl.jump_src = 1'b1;
            o_ctrl.link     = 1'b1;
          end
          default: o_ctrl.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: o_ctrl.alu_src = 1'b1;
      OP_SLTI: begin o_ctrl.alu_src = 1'b1; o_ctrl.alu_opcode = ALU_SLT;  end
      OP_SLTIU: begin o_ctrl.alu_src = 1'b1; o_ctrl.alu_opcode = ALU_SLTU; end
      OP_ANDI: begin o_ctrl.alu_src = 1'b1; o_ctrl.alu_opcode = ALU_AND;  end
      OP_ORI:  begin o_ctrl.alu_src = 1'b1; o_ctrl.alu_opcode = ALU_OR;   end
      OP_XORI: begin o_ctrl.alu_src = 1'b1; o_ctrl.alu_opcode = ALU_XOR;  end
      OP_BEQ:  begin o_ctrl.is_branch = 1'b1; o_ctrl.branch_type = BR_EQ;  end
      OP_BNE:  begin o_ctrl.is_branch = 1'b1; o_ctrl.branch_type = BR_NE;  end
      OP_BLEZ: begin o_ctrl.is_branch = 1'b1; o_ctrl.branch_type = BR_LEZ; end
      OP_BGTZ: begin o_ctrl.is_branch = 1'b1; o_ctrl.branch_type = BR_GTZ; end
      OP_J:    o_ctrl.is_jump = 1'b1;
      OP_JAL:  begin o_ctrl.is_jump = 1'b1; o_ctrl.link = 1'b1; end
      OP_LW:   begin o_ctrl.alu_src = 1'b1; o_ctrl.is_load  = 1'b1; end
      OP_SW:   begin o_ctrl.alu_src = 1'b1; o_ctrl.is_store = 1'b1; end
      OP_HALT: ;
      default: o_ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_processor.sv
// Multi-cycle R/I/J core: FETCH -> DECODE -> EXECUTE -> (MEM) -> (WRITEBACK).
// ROM and RAM are reached over req/ack handshakes, so either may stall.
// Ports:
//   clk, reset (async active-low), enable (0 freezes all state)
//   rom_req/rom_address/rom_data_in/rom_ack      - instruction fetch
//   ram_req/ram_read_write/ram_address/
//   ram_data_write_out/ram_data_read_in/ram_ack   - data access (rw 1 = write)
//   halted, illegal_opcode, bus_error            - status (traps are sticky)
//   retired_count                                 - completed instructions, wraps
module multicycle_processor
  import proc_pkg::*;
#(
  parameter int NUM_ROM_ADDRESS = 256,
  parameter int NUM_RAM_ADDRESS = 256,
  parameter int RESET_PC        = 0,
  parameter int BUS_TIMEOUT     = 15,
  parameter int COUNT_WIDTH     = 16,
  localparam int ROM_AW = $clog2(NUM_ROM_ADDRESS),
  localparam int RAM_AW = $clog2(NUM_RAM_ADDRESS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   rom_req,
  output logic [ROM_AW-1:0]      rom_address,
  input  logic [31:0]            rom_data_in,
  input  logic                   rom_ack,
  output logic                   ram_req,
  output logic                   ram_read_write,
  output logic [RAM_AW-1:0]      ram_address,
  output logic [31:0]            ram_data_write_out,
  input  logic [31:0]            ram_data_read_in,
  input  logic                   ram_ack,
  output logic                   halted,
  output logic                   illegal_opcode,
  output logic                   bus_error,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  localparam int WAIT_W = 16;

  state_t                 r_state, w_next;
  logic [ROM_AW-1:0]      r_pc, w_pc_next, w_pc_inc;
  logic [31:0]            r_ir, r_a, r_b, r_alu, r_mdr;
  logic [31:0]            r_regs [32];
  logic [WAIT_W-1:0]      r_wait;
  logic                   r_illegal, r_bus_error;
  logic [COUNT_WIDTH-1:0] r_retired;

  ctrl_t       w_ctrl;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [31:0] w_imm_se, w_rs_val, w_rt_val, w_alu_b, w_alu_y;
  logic        w_taken, w_timeout;
  logic        w_retire, w_rf_we, w_ld_ir, w_ld_ab, w_ld_alu, w_ld_mdr;
  logic        w_set_illegal, w_set_bus_err;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;

  multicycle_decoder u_decoder (
    .i_opcode (r_ir[OP_MSB:OP_LSB]),
    .i_funct  (r_ir[FN_MSB:FN_LSB]),
    .o_ctrl   (w_ctrl)
  );

  assign w_rs     = r_ir[RS_MSB:RS_LSB];
  assign w_rt     = r_ir[RT_MSB:RT_LSB];
  assign w_rd     = r_ir[RD_MSB:RD_LSB];
  assign w_shamt  = r_ir[SH_MSB:SH_LSB];
  assign w_imm_se = {{16{r_ir[IMM_MSB]}}, r_ir[IMM_MSB:0]};
  assign w_pc_inc = r_pc + ROM_AW'(1);

  // r0 is hard-wired to zero on the read side as well as never written.
  assign w_rs_val = (w_rs == 5'd0) ? '0 : r_regs[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? '0 : r_regs[w_rt];

  assign w_alu_b = w_ctrl.alu_src ? w_imm_se : r_b;
  assign w_alu_y = alu_eval(w_ctrl.alu_opcode, r_a, w_alu_b, w_shamt);

  always_comb begin
    case (w_ctrl.branch_type)
      BR_EQ:   w_taken = (r_a == r_b);
      BR_NE:   w_taken = (r_a != r_b);
      BR_LEZ:  w_taken = ($signed(r_a) <= 0);
      default: w_taken = ($signed(r_a) > 0);
    endcase
  end

  // Fires on the BUS_TIMEOUT-th consecutive cycle without ack.
  assign w_timeout = (BUS_TIMEOUT != 0) && (r_wait == WAIT_W'(BUS_TIMEOUT - 1));

  always_comb begin
    w_next        = r_state;
    w_pc_next     = r_pc;
    w_retire      = 1'b0;
    w_rf_we       = 1'b0;
    w_rf_waddr    = 5'd0;
    w_rf_wdata    = '0;
    w_ld_ir       = 1'b0;
    w_ld_ab       = 1'b0;
    w_ld_alu      = 1'b0;
    w_ld_mdr      = 1'b0;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;
    case (r_state)
      FETCH: begin
        if (rom_ack) begin
          w_ld_ir = 1'b1;
          w_next  = DECODE;
        end else if (w_timeout) begin
          w_set_bus_err = 1'b1;
          w_next        = HALT;
        end
      end
      DECODE: begin
        if (r_ir[OP_MSB:OP_LSB] == OP_HALT) begin
          w_retire = 1'b1;
          w_next   = HALT;
        end else if (w_ctrl.illegal) begin
          w_set_illegal = 1'b1;
          w_next        = HALT;
        end else begin
          w_ld_ab = 1'b1;
          w_next  = EXECUTE;
        end
      end
      EXECUTE: begin
        if (w_ctrl.is_branch) begin
          w_pc_next = w_taken ? r_ir[ROM_AW-1:0] : w_pc_inc;
          w_retire  = 1'b1;
          w_next    = FETCH;
        end else if (w_ctrl.is_jump) begin
          w_pc_next  = w_ctrl.jump_src ? r_a[ROM_AW-1:0] : r_ir[ROM_AW-1:0];
          w_rf_we    = w_ctrl.link;
          w_rf_waddr = w_ctrl.jump_src ? w_rd : 5'd31;
          w_rf_wdata = {{(32-ROM_AW){1'b0}}, w_pc_inc};
          w_retire   = 1'b1;
          w_next     = FETCH;
        end else begin
          w_ld_alu = 1'b1;
          w_next   = (w_ctrl.is_load || w_ctrl.is_store) ? MEM : WRITEBACK;
        end
      end
      MEM: begin
        if (ram_ack) begin
          if (w_ctrl.is_store) begin
            w_pc_next = w_pc_inc;
            w_retire  = 1'b1;
            w_next    = FETCH;
          end else begin
            w_ld_mdr = 1'b1;
            w_next   = WRITEBACK;
          end
        end else if (w_timeout) begin
          w_set_bus_err = 1'b1;
          w_next        = HALT;
        end
      end
      WRITEBACK: begin
        w_rf_we    = 1'b1;
        w_rf_waddr = w_ctrl.reg_dst ? w_rd : w_rt;
        w_rf_wdata = w_ctrl.is_load ? r_mdr : r_alu;
        w_pc_next  = w_pc_inc;
        w_retire   = 1'b1;
        w_next     = FETCH;
      end
      HALT: w_next = HALT;
      default: w_next = HALT;
    endcase
  end

  // Control state: FSM, PC, wait counter, sticky traps, retire counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= FETCH;
      r_pc        <= ROM_AW'(RESET_PC);
      r_wait      <= '0;
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
      r_retired   <= '0;
    end else if (enable) begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      // Counts only while a handshake state is held, i.e. ack is still low.
      if ((w_next == r_state) && ((r_state == FETCH) || (r_state == MEM)))
        r_wait <= r_wait + WAIT_W'(1);
      else
        r_wait <= '0;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_bus_err) r_bus_error <= 1'b1;
      if (w_retire) r_retired <= r_retired + COUNT_WIDTH'(1);
    end
  end

  // Register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (enable && w_rf_we && (w_rf_waddr != 5'd0)) begin
      r_regs[w_rf_waddr] <= w_rf_wdata;
    end
  end

  // Datapath latches between FSM steps.
  always_ff @(posedge clk) begin
    if (enable) begin
      if (w_ld_ir) r_ir <= rom_data_in;
      if (w_ld_ab) begin
        r_a <= w_rs_val;
        r_b <= w_rt_val;
      end
      if (w_ld_alu) r_alu <= w_alu_y;
      if (w_ld_mdr) r_mdr <= ram_data_read_in;
    end
  end

  // Gating with reset makes rom_req drop the instant reset asserts, even
  // though the reset state itself is FETCH.
  assign rom_req            = reset && (r_state == FETCH);
  assign rom_address        = r_pc;
  assign ram_req            = reset && (r_state == MEM);
  assign ram_read_write     = (r_state == MEM) && w_ctrl.is_store;
  assign ram_address        = r_alu[RAM_AW-1:0];
  assign ram_data_write_out = r_b;
  assign halted             = (r_state == HALT);
  assign illegal_opcode     = r_illegal;
  assign bus_error          = r_bus_error;
  assign retired_count      = r_retired;

endmodule
